// File: rtl/adc_clk_div_gen.sv
// Run-time reconfigurable clock divider / phase generator for the ADC capture path.
// A LOAD -> SETTLE -> LOCKED sequencer applies new per-channel ratios and phases atomically.
module adc_clk_div_gen #(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = 8,
  parameter int DEF_DIV     = 4,
  parameter int DEF_PHASE   = 0,
  parameter int LOCK_CYCLES = 16
) (
  input  logic                    refclk,
  input  logic                    rst,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [NUM_CH*CNT_W-1:0] cfg_div,
  input  logic [NUM_CH*CNT_W-1:0] cfg_phase,
  output logic [NUM_CH-1:0]       outclk,
  output logic [NUM_CH-1:0]       outclk_en,
  output logic                    locked
);

  localparam int LOCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  typedef enum logic [1:0] {ST_LOAD, ST_SETTLE, ST_LOCKED} state_t;

  state_t                         state_q, state_d;
  logic [LOCK_W-1:0]              settle_q, settle_d;
  logic [NUM_CH-1:0][CNT_W-1:0]   div_q, div_d;
  logic [NUM_CH-1:0][CNT_W-1:0]   phase_q, phase_d;
  logic [NUM_CH-1:0][CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_CH-1:0]              started_q, started_d;
  logic [NUM_CH-1:0]              outclk_q, outclk_d;
  logic [NUM_CH-1:0]              en_q, en_d;
  logic                           locked_q, locked_d;
  logic                           accept;

  function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] d);
    return (d < CNT_W'(2)) ? CNT_W'(2) : d;
  endfunction

  function automatic logic [CNT_W-1:0] clamp_phase(input logic [CNT_W-1:0] d,
                                                   input logic [CNT_W-1:0] p);
    return (p >= d) ? d - CNT_W'(1) : p;
  endfunction

  // High for ceil(D/2) counts starting at c==0.
  function automatic logic in_high(input logic [CNT_W-1:0] c, input logic [CNT_W-1:0] d);
    logic [CNT_W:0] half;
    half = ({1'b0, d} + (CNT_W+1)'(1)) >> 1;
    return {1'b0, c} < half;
  endfunction

  // cfg_ready depends only on the state register, so cfg_* never reaches an output combinationally.
  assign cfg_ready = (state_q != ST_LOAD);
  assign accept    = cfg_valid & cfg_ready;

  // NOTE: every signal gets a default before the case/if logic, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    div_d     = div_q;
    phase_d   = phase_q;
    cnt_d     = cnt_q;
    started_d = started_q;
    outclk_d  = '0;
    en_d      = '0;

    case (state_q)
      ST_LOAD: begin
        state_d   = ST_SETTLE;
        settle_d  = '0;
        started_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
          div_d[i]   = clamp_div(div_q[i]);
          phase_d[i] = clamp_phase(div_d[i], phase_q[i]);
          cnt_d[i]   = (phase_d[i] == '0) ? '0 : div_d[i] - phase_d[i];
        end
      end
      ST_SETTLE: begin
        if (settle_q == LOCK_W'(LOCK_CYCLES - 1)) state_d = ST_LOCKED;
        else                                      settle_d = settle_q + LOCK_W'(1);
      end
      default: ;
    endcase

    if (state_q != ST_LOAD) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_d[i]     = (cnt_q[i] == div_q[i] - CNT_W'(1)) ? '0 : cnt_q[i] + CNT_W'(1);
        started_d[i] = started_q[i] | (cnt_q[i] == '0);
        // Hold the clock low until the first phase-aligned c==0 so every rise carries a strobe.
        outclk_d[i]  = (started_q[i] | (cnt_q[i] == '0)) & in_high(cnt_q[i], div_q[i]);
        en_d[i]      = (cnt_q[i] == '0);
      end
    end

    // A new configuration always wins, including over the SETTLE terminal count.
    if (accept) begin
      state_d  = ST_LOAD;
      outclk_d = '0;
      en_d     = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        div_d[i]   = cfg_div[i*CNT_W +: CNT_W];
        phase_d[i] = cfg_phase[i*CNT_W +: CNT_W];
      end
    end

    locked_d = (state_d == ST_LOCKED);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_LOAD;
      settle_q  <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i]   <= CNT_W'(DEF_DIV);
        phase_q[i] <= CNT_W'(DEF_PHASE);
      end
      cnt_q     <= '0;
      started_q <= '0;
      outclk_q  <= '0;
      en_q      <= '0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      div_q     <= div_d;
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      started_q <= started_d;
      outclk_q  <= outclk_d;
      en_q      <= en_d;
      locked_q  <= locked_d;
    end
  end

  assign outclk    = outclk_q;
  assign outclk_en = en_q;
  assign locked    = locked_q;

endmodule
